// File: rtl/inst_loader_if.sv
// Byte-receive and instruction-memory write bundle for the instruction loader.
// master = loader side (consumes bytes, drives the write port); slave = UART/memory side.
interface inst_loader_if #(
  parameter int NB_DATA = 32,
  parameter int NBYTE   = 8
);
  logic [NBYTE-1:0]   rx_data;
  logic               rx_valid;
  logic               en_write;
  logic [NB_DATA-1:0] addr_write;
  logic [NB_DATA-1:0] data_write;

  modport master (
    input  rx_data, rx_valid,
    output en_write, addr_write, data_write
  );

  modport slave (
    output rx_data, rx_valid,
    input  en_write, addr_write, data_write
  );
endinterface

// File: rtl/inst_loader.sv
// Assembles little-endian UART bytes into words and writes them to sequential instruction-memory
// addresses until the halt word or a full memory. Optional macro: LOADER_TIMEOUT_EN (inter-byte timeout).
module inst_loader #(
  parameter int                 NB_DATA        = 32,
  parameter int                 NBYTE          = 8,
  parameter int                 N_ELEMENTS     = 128,
  parameter logic [NB_DATA-1:0] HALT_WORD      = 32'hfc000000,
  parameter int                 TIMEOUT_CYCLES = 50000
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                start_i,
  inst_loader_if.master       bus,
  output logic                busy_o,
  output logic                load_done_o,
  output logic                overflow_o,
  output logic [7:0]          word_count_o,
  output logic                timeout_o
);

  localparam int N_BYTES   = NB_DATA / NBYTE;
  localparam int BCW       = $clog2(N_BYTES);
  localparam int AW        = $clog2(N_ELEMENTS);
  localparam int LAST_BYTE = N_BYTES - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_WRITE, ST_DONE} state_t;

  state_t                    state_q;
  logic [BCW-1:0]            byte_cnt_q;
  logic [NB_DATA-NBYTE-1:0]  word_q;        // lower bytes; the last byte goes straight to data_write_q
  logic [AW-1:0]             addr_q;
  logic                      en_write_q;
  logic [NB_DATA-1:0]        data_write_q;
  logic                      busy_q;
  logic                      load_done_q;
  logic                      overflow_q;
  logic [7:0]                word_count_q;
  logic                      timeout_q;

  logic is_halt;
  logic is_full;
  logic load_end;
  logic rx_take;

  assign is_halt  = (data_write_q == HALT_WORD);
  assign is_full  = (addr_q == AW'(N_ELEMENTS - 1));
  assign load_end = (state_q == ST_WRITE) && (is_halt || is_full);
  // A byte arriving during the write cycle starts the next word, unless that write ends the load.
  assign rx_take  = bus.rx_valid && ((state_q == ST_RECV) || ((state_q == ST_WRITE) && !load_end));

`ifdef LOADER_TIMEOUT_EN
  localparam int TCW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TCW-1:0] idle_cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      addr_q       <= '0;
      en_write_q   <= 1'b0;
      data_write_q <= '0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
      timeout_q    <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      idle_cnt_q   <= '0;
`endif
    end else begin
      en_write_q <= 1'b0;
      timeout_q  <= 1'b0;

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q      <= ST_RECV;
            busy_q       <= 1'b1;
            load_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
            addr_q       <= '0;
            word_count_q <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
          end
        end
        ST_WRITE: begin
          if (word_count_q != 8'hff) word_count_q <= word_count_q + 8'd1;
          if (is_halt || is_full) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            load_done_q <= 1'b1;
            overflow_q  <= !is_halt;
          end else begin
            state_q <= ST_RECV;
            addr_q  <= addr_q + AW'(1);
          end
        end
        default: ;
      endcase

`ifdef LOADER_TIMEOUT_EN
      if (state_q == ST_RECV && byte_cnt_q != '0 && !rx_take) begin
        if (idle_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
          idle_cnt_q <= '0;
          byte_cnt_q <= '0;
          word_q     <= '0;
          timeout_q  <= 1'b1;
        end else begin
          idle_cnt_q <= idle_cnt_q + TCW'(1);
        end
      end else begin
        idle_cnt_q <= '0;
      end
`endif

      if (rx_take) begin
        if (byte_cnt_q == BCW'(LAST_BYTE)) begin
          data_write_q <= {bus.rx_data, word_q};
          en_write_q   <= 1'b1;
          byte_cnt_q   <= '0;
          state_q      <= ST_WRITE;
        end else begin
          for (int k = 0; k < LAST_BYTE; k++) begin
            if (byte_cnt_q == BCW'(k)) word_q[k*NBYTE +: NBYTE] <= bus.rx_data;
          end
          byte_cnt_q <= byte_cnt_q + BCW'(1);
        end
      end
    end
  end

  assign bus.en_write   = en_write_q;
  assign bus.addr_write = {{(NB_DATA - AW){1'b0}}, addr_q};
  assign bus.data_write = data_write_q;
  assign busy_o         = busy_q;
  assign load_done_o    = load_done_q;
  assign overflow_o     = overflow_q;
  assign word_count_o   = word_count_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: a byte-stream model predicts every memory write and the final
// load status; one negedge process checks each write against it, plus hand-computed literals.
module tb_inst_loader;
  localparam int          TO   = 16;
  localparam int          NEL  = 128;
  localparam logic [31:0] HALT = 32'hfc000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, load_done, ovf, tmo;
  logic [7:0] wcnt;

  inst_loader_if #(.NB_DATA(32), .NBYTE(8)) bus ();

  always #5 clk = ~clk;

  inst_loader #(
    .NB_DATA(32), .NBYTE(8), .N_ELEMENTS(NEL), .HALT_WORD(HALT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock_i(clk), .reset_i(rst_n), .start_i(start), .bus(bus),
    .busy_o(busy), .load_done_o(load_done), .overflow_o(ovf),
    .word_count_o(wcnt), .timeout_o(tmo)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-stream model: a load is a list of bytes, every 4 form a little-endian word.
  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t        exp_q[$];
  logic [7:0] m_bytes[$];
  int         m_addr = 0, m_count = 0;
  bit         m_active = 0, m_done = 0, m_ovf = 0;

  function automatic void model_byte(input logic [7:0] b);
    logic [31:0] w;
    if (!m_active) return;
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      m_bytes.delete();
      exp_q.push_back('{m_addr, w});
      m_count = (m_count < 255) ? m_count + 1 : 255;
      if (w == HALT) begin
        m_active = 0; m_done = 1; m_ovf = 0;
      end else if (m_addr == NEL - 1) begin
        m_active = 0; m_done = 1; m_ovf = 1;
      end else begin
        m_addr++;
      end
    end
  endfunction

  function automatic void model_start();
    if (m_active) return;
    m_active = 1; m_done = 0; m_ovf = 0; m_addr = 0; m_count = 0;
    m_bytes.delete();
  endfunction

  function automatic void model_reset();
    m_active = 0; m_done = 0; m_ovf = 0; m_addr = 0; m_count = 0;
    m_bytes.delete();
    exp_q.delete();
  endfunction

  // Compare process: every write strobe must match the next predicted write.
  int          n_writes = 0, n_tmo = 0;
  logic [31:0] last_addr = '0, last_data = '0;
  logic        prev_en = 1'b0, prev_tmo = 1'b0;
  wr_t         e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en  = 1'b0;
      prev_tmo = 1'b0;
    end else begin
      if (bus.en_write) begin
        n_writes++;
        last_addr = bus.addr_write;
        last_data = bus.data_write;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write", bus.addr_write, bus.data_write);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", bus.addr_write, e.addr);
          chk("write_data", bus.data_write, e.data);
        end
      end
      chk("en_write_single_cycle", {31'b0, bus.en_write & prev_en}, 32'h0);
      if (tmo) n_tmo++;
`ifdef LOADER_TIMEOUT_EN
      chk("timeout_single_cycle", {31'b0, tmo & prev_tmo}, 32'h0);
`else
      chk("timeout_tied_low", {31'b0, tmo}, 32'h0);
`endif
      prev_en  = bus.en_write;
      prev_tmo = tmo;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    model_byte(b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic do_start();
    start = 1'b1;
    model_start();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
`ifdef LOADER_TIMEOUT_EN
    if (m_active && n >= TO && m_bytes.size() > 0) m_bytes.delete();
`endif
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle_status(input string tag);
    repeat (3) @(posedge clk);
    #2;
    chk({tag, "_busy"},      {31'b0, busy},      {31'b0, m_active});
    chk({tag, "_load_done"}, {31'b0, load_done}, {31'b0, m_done});
    chk({tag, "_overflow"},  {31'b0, ovf},       {31'b0, m_ovf});
    chk({tag, "_word_count"}, {24'b0, wcnt},     m_count);
    chk({tag, "_pending_writes"}, exp_q.size(),  32'd0);
  endtask

  initial begin
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_en_write",  {31'b0, bus.en_write}, 32'h0);
    chk("reset_addr",      bus.addr_write, 32'h0);
    chk("reset_data",      bus.data_write, 32'h0);
    chk("reset_busy",      {31'b0, busy}, 32'h0);
    chk("reset_load_done", {31'b0, load_done}, 32'h0);
    chk("reset_word_count", {24'b0, wcnt}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // T1: first word, with a start pulse mid-word that must be ignored
    do_start();
    send_byte(8'h78);
    send_byte(8'h56);
    do_start();
    send_byte(8'h34);
    send_byte(8'h12);
    chk("t1_en_write", {31'b0, bus.en_write}, 32'h1);
    chk("t1_addr", bus.addr_write, 32'h0);
    chk("t1_data", bus.data_write, 32'h12345678);
    chk("t1_busy", {31'b0, busy}, 32'h1);
    chk("t1_load_done", {31'b0, load_done}, 32'h0);
    settle_status("t1");
    chk("t1_writes", n_writes, 32'd1);

    // T2: two more words ending with HALT; later bytes are ignored
    send_word(32'hdeadbeef);
    send_word(HALT);
    settle_status("t2");
    chk("t2_load_done", {31'b0, load_done}, 32'h1);
    chk("t2_overflow", {31'b0, ovf}, 32'h0);
    chk("t2_word_count", {24'b0, wcnt}, 32'd3);
    chk("t2_last_addr", last_addr, 32'd2);
    chk("t2_last_data", last_data, HALT);
    send_word(32'h01020304);
    settle_status("t2_after");
    chk("t2_no_more_writes", n_writes, 32'd3);

    // T3: memory filled without HALT
    do_start();
    for (int i = 0; i < NEL; i++) send_word(32'h1000_0000 + i);
    settle_status("t3");
    chk("t3_last_addr", last_addr, 32'd127);
    chk("t3_overflow", {31'b0, ovf}, 32'h1);
    chk("t3_word_count", {24'b0, wcnt}, 32'd128);
    chk("t3_writes", n_writes, 32'd131);

    // T3b: HALT lands exactly on the last address: halt wins, no overflow
    do_start();
    for (int i = 0; i < NEL - 1; i++) send_word(32'h2000_0000 + i);
    send_word(HALT);
    settle_status("t3b");
    chk("t3b_overflow", {31'b0, ovf}, 32'h0);
    chk("t3b_load_done", {31'b0, load_done}, 32'h1);
    chk("t3b_last_addr", last_addr, 32'd127);
    chk("t3b_word_count", {24'b0, wcnt}, 32'd128);

    // T4: eight back-to-back bytes, byte 4 strobed during the write cycle
    do_start();
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    settle_status("t4");
    chk("t4_last_addr", last_addr, 32'd1);
    chk("t4_last_data", last_data, 32'h08070605);

    // T5: reset after two bytes drops the partial word
    send_byte(8'haa);
    send_byte(8'hbb);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_reset_busy", {31'b0, busy}, 32'h0);
    chk("t5_reset_word_count", {24'b0, wcnt}, 32'h0);
    chk("t5_reset_addr", bus.addr_write, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_start();
    send_word(32'h04030201);
    chk("t5_en_write", {31'b0, bus.en_write}, 32'h1);
    chk("t5_addr", bus.addr_write, 32'h0);
    chk("t5_data", bus.data_write, 32'h04030201);
    settle_status("t5");

    // T6: reset asserted during the write cycle kills the strobe at once
    send_word(32'hcafef00d);
    chk("t6_en_write_before", {31'b0, bus.en_write}, 32'h1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_en_write_async", {31'b0, bus.en_write}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    settle_status("t6");

    // T7: partial word followed by a long idle gap
    begin
      int w0;
      w0 = n_writes;
      do_start();
      send_byte(8'h11);
      send_byte(8'h22);
      idle(20);
      send_byte(8'h33);
      send_byte(8'h44);
      send_byte(8'h55);
      send_byte(8'h66);
      settle_status("t7");
      chk("t7_writes", n_writes - w0, 32'd1);
      chk("t7_addr", last_addr, 32'h0);
`ifdef LOADER_TIMEOUT_EN
      chk("t7_data", last_data, 32'h66554433);
      chk("t7_timeouts", n_tmo, 32'd1);
`else
      chk("t7_data", last_data, 32'h44332211);
      chk("t7_timeouts", n_tmo, 32'd0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
